// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit memory master.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/mask placement, load extraction and
// extension, and natural-alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata,
  output logic        o_misaligned
);

  logic [3:0]  w_bytes;
  logic [3:0]  w_low_mask;
  logic [5:0]  w_bit_off;
  logic [63:0] w_rshift;

  assign w_bytes    = size_bytes(i_size);
  assign w_low_mask = w_bytes - 4'd1;
  assign w_bit_off  = {i_offset, 3'b000};

  assign o_misaligned = |({1'b0, i_offset} & w_low_mask);
  assign o_wmask      = 8'((16'd1 << w_bytes) - 16'd1) << i_offset;
  assign o_wdata      = i_wdata << w_bit_off;
  assign w_rshift     = i_rdata >> w_bit_off;

  always_comb begin
    o_rdata = w_rshift;
    unique case (i_size)
      SZ_B: o_rdata = i_unsigned ? {56'd0, w_rshift[7:0]}
                                 : {{56{w_rshift[7]}}, w_rshift[7:0]};
      SZ_H: o_rdata = i_unsigned ? {48'd0, w_rshift[15:0]}
                                 : {{48{w_rshift[15]}}, w_rshift[15:0]};
      SZ_W: o_rdata = i_unsigned ? {32'd0, w_rshift[31:0]}
                                 : {{32{w_rshift[31]}}, w_rshift[31:0]};
      SZ_D: o_rdata = w_rshift;
      default: o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one request in flight, aligned single-cycle memory access,
// registered response with extended load data or a misalignment error.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wen,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_err,
  output logic            o_mem_valid,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_raddr,
  output logic [XLEN-1:0] o_mem_waddr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [7:0]      o_mem_wmask,
  input  logic [XLEN-1:0] i_mem_rdata
);

  lsu_state_e r_state, w_state_next;

  logic       r_req_wen;
  logic       r_req_unsigned;
  logic [2:0] r_req_offset;
  logic [1:0] r_req_size;

  logic            r_mem_valid, w_mem_valid_d;
  logic            r_mem_wen, w_mem_wen_d;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_d;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_d;
  logic [7:0]      r_mem_wmask, w_mem_wmask_d;
  logic            r_resp_valid, w_resp_valid_d;
  logic            r_resp_err, w_resp_err_d;
  logic [XLEN-1:0] r_resp_rdata, w_resp_rdata_d;

  logic            w_idle;
  logic            w_accept;
  logic [2:0]      w_al_offset;
  logic [1:0]      w_al_size;
  logic            w_al_unsigned;
  logic [7:0]      w_al_wmask;
  logic [XLEN-1:0] w_al_wdata;
  logic [XLEN-1:0] w_al_rdata;
  logic            w_misaligned;

  assign w_idle      = (r_state == StIdle);
  assign o_req_ready = w_idle && !i_reset;
  assign w_accept    = i_req_valid && o_req_ready;

  // One aligner serves both phases: live request fields in IDLE, latched ones after.
  assign w_al_offset   = w_idle ? i_req_addr[2:0] : r_req_offset;
  assign w_al_size     = w_idle ? i_req_size      : r_req_size;
  assign w_al_unsigned = w_idle ? i_req_unsigned  : r_req_unsigned;

  lsu_align u_align (
    .i_offset     (w_al_offset),
    .i_size       (w_al_size),
    .i_unsigned   (w_al_unsigned),
    .i_wdata      (i_req_wdata),
    .i_rdata      (i_mem_rdata),
    .o_wmask      (w_al_wmask),
    .o_wdata      (w_al_wdata),
    .o_rdata      (w_al_rdata),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_misaligned ? StResp : StIssue;
      StIssue: w_state_next = StCapt;
      StCapt:  w_state_next = StResp;
      StResp:  if (i_resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_mem_valid_d  = 1'b0;
    w_mem_wen_d    = 1'b0;
    w_mem_addr_d   = '0;
    w_mem_wdata_d  = '0;
    w_mem_wmask_d  = '0;
    w_resp_valid_d = 1'b0;
    w_resp_err_d   = 1'b0;
    w_resp_rdata_d = '0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_resp_valid_d = 1'b1;
            w_resp_err_d   = 1'b1;
          end else begin
            w_mem_valid_d = 1'b1;
            w_mem_wen_d   = i_req_wen;
            w_mem_addr_d  = {i_req_addr[XLEN-1:3], 3'b000};
            w_mem_wdata_d = w_al_wdata;
            w_mem_wmask_d = w_al_wmask;
          end
        end
      end
      StIssue: begin
      end
      StCapt: begin
        w_resp_valid_d = 1'b1;
        w_resp_rdata_d = r_req_wen ? '0 : w_al_rdata;
      end
      StResp: begin
        if (!i_resp_ready) begin
          w_resp_valid_d = r_resp_valid;
          w_resp_err_d   = r_resp_err;
          w_resp_rdata_d = r_resp_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_valid  <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_mem_valid  <= w_mem_valid_d;
      r_mem_wen    <= w_mem_wen_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_wdata  <= w_mem_wdata_d;
      r_mem_wmask  <= w_mem_wmask_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_err   <= w_resp_err_d;
      r_resp_rdata <= w_resp_rdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req_wen      <= 1'b0;
      r_req_unsigned <= 1'b0;
      r_req_offset   <= '0;
      r_req_size     <= '0;
    end else if (w_accept) begin
      r_req_wen      <= i_req_wen;
      r_req_unsigned <= i_req_unsigned;
      r_req_offset   <= i_req_addr[2:0];
      r_req_size     <= i_req_size;
    end
  end

  assign o_mem_valid  = r_mem_valid;
  assign o_mem_wen    = r_mem_wen;
  assign o_mem_raddr  = r_mem_addr;
  assign o_mem_waddr  = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wmask  = r_mem_wmask;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: byte-array reference memory, one-cycle responder.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_valid, mem_wen;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mem_pulse = 0;
  int cyc = 0;
  int mem_cycles[$];

  logic [7:0]  ref_mem [0:127];
  logic [63:0] mem [0:15];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [63:0] pre_val = '0;

  always #5 clk = ~clk;

  lsu_mem_master #(.XLEN(64)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wen      (req_wen),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_mem_valid    (mem_valid),
    .o_mem_wen      (mem_wen),
    .o_mem_raddr    (mem_raddr),
    .o_mem_waddr    (mem_waddr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_wmask    (mem_wmask),
    .i_mem_rdata    (mem_rdata)
  );

  // One-cycle responder covering 0x8000_0000..0x8000_007F.
  always @(posedge clk) begin
    if (mem_valid && !mem_wen) mem_rdata <= mem[mem_raddr[6:3]];
    else mem_rdata <= '0;
    if (mem_valid && mem_wen) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) mem[mem_waddr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (pre_en) mem[pre_idx] <= pre_val;
    if (mem_valid) begin
      n_mem_pulse = n_mem_pulse + 1;
      mem_cycles.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [63:0] val);
    pre_en = 1'b1; pre_idx = 4'(idx); pre_val = val;
    for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = val[8*b +: 8];
    step();
    pre_en = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic ref_misaligned(input logic [63:0] a, input logic [1:0] sz);
    return (int'(a[6:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [63:0] v = '0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[6:0]) + i];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a[6:0]) + i] = wd[8*i +: 8];
  endtask

  // Drives one request with resp_ready high; returns response and latency (-1 on timeout).
  task automatic run_req(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output logic [63:0] rd, output logic err, output int lat,
                         output int pulses);
    int guard = 0;
    int p0;
    while (!req_ready && guard < 10) begin step(); guard++; end
    p0 = n_mem_pulse;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin step(); lat++; end
    if (!resp_valid) lat = -1;
    rd = resp_rdata;
    err = resp_err;
    step();
    pulses = n_mem_pulse - p0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b1;
    step();
    for (int w = 0; w < 16; w++) set_word(w, {$urandom, $urandom});
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready);
    else n_pass++;
    n_checks++;
    if ({mem_valid, mem_wen, mem_wmask, mem_waddr, mem_wdata} !== '0)
      $display("FAIL reset_mem_outputs got valid=%b wen=%b mask=%h", mem_valid, mem_wen,
               mem_wmask);
    else n_pass++;
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata} !== '0)
      $display("FAIL reset_resp_outputs got valid=%b err=%b rdata=%h", resp_valid, resp_err,
               resp_rdata);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready);
    else n_pass++;
  endtask

  task automatic test_store_byte();
    logic [63:0] rd;
    logic err;
    int lat, pulses;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0005; req_wdata = 64'hAB;
    req_size = SZ_B; req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (mem_valid !== 1'b1 || mem_wen !== 1'b1)
      $display("FAIL store_c1_valid got valid=%b wen=%b exp 1/1", mem_valid, mem_wen);
    else n_pass++;
    n_checks++;
    if (mem_waddr !== 64'h8000_0000 || mem_raddr !== 64'h8000_0000)
      $display("FAIL store_c1_addr got w=%h r=%h exp=80000000", mem_waddr, mem_raddr);
    else n_pass++;
    n_checks++;
    if (mem_wmask !== 8'h20) $display("FAIL store_c1_wmask got=%h exp=20", mem_wmask);
    else n_pass++;
    n_checks++;
    if (mem_wdata !== 64'h0000_AB00_0000_0000)
      $display("FAIL store_c1_wdata got=%h exp=0000ab0000000000", mem_wdata);
    else n_pass++;
    step();
    n_checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL store_c2_idle got mem_valid=%b resp_valid=%b exp 0/0", mem_valid,
               resp_valid);
    else n_pass++;
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'd0 || resp_err !== 1'b0)
      $display("FAIL store_c3_resp got valid=%b rdata=%h err=%b exp 1/0/0", resp_valid,
               resp_rdata, resp_err);
    else n_pass++;
    step();
    ref_store(64'h8000_0005, 64'hAB, SZ_B);
    run_req(1'b0, 64'h8000_0005, '0, SZ_B, 1'b0, rd, err, lat, pulses);
    n_checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFAB || rd !== ref_load(64'h8000_0005, SZ_B, 1'b0))
      $display("FAIL store_readback got=%h exp=ffffffffffffffab", rd);
    else n_pass++;
  endtask

  task automatic test_load_half();
    logic [63:0] rd;
    logic err;
    int lat, pulses;
    set_word(0, 64'h1122_3344_8899_AABB);
    run_req(1'b0, 64'h8000_0002, '0, SZ_H, 1'b0, rd, err, lat, pulses);
    n_checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_8899 || err !== 1'b0 || lat !== 3)
      $display("FAIL load_half_signed got rd=%h err=%b lat=%0d exp ffffffffffff8899/0/3", rd,
               err, lat);
    else n_pass++;
    run_req(1'b0, 64'h8000_0002, '0, SZ_H, 1'b1, rd, err, lat, pulses);
    n_checks++;
    if (rd !== 64'h0000_0000_0000_8899 || err !== 1'b0)
      $display("FAIL load_half_unsigned got rd=%h err=%b exp 8899/0", rd, err);
    else n_pass++;
    run_req(1'b0, 64'h8000_0000, '0, SZ_D, 1'b0, rd, err, lat, pulses);
    n_checks++;
    if (rd !== 64'h1122_3344_8899_AABB)
      $display("FAIL load_double_aligned got=%h exp=112233448899aabb", rd);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [63:0] rd;
    logic err;
    int lat, pulses;
    run_req(1'b0, 64'h8000_0006, '0, SZ_W, 1'b0, rd, err, lat, pulses);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 64'd0)
      $display("FAIL misaligned_resp got lat=%0d err=%b rd=%h exp 1/1/0", lat, err, rd);
    else n_pass++;
    n_checks++;
    if (pulses !== 0) $display("FAIL misaligned_no_mem got pulses=%0d exp=0", pulses);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_rd, rd;
    logic err, bad;
    int guard, p0, lat, pulses;
    exp_rd = ref_load(64'h8000_0008, SZ_D, 1'b0);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008; req_size = SZ_D;
    req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 10) begin step(); guard++; end
    p0 = n_mem_pulse;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0 ||
          mem_valid !== 1'b0) bad = 1'b1;
      step();
    end
    n_checks++;
    if (bad !== 1'b0 || n_mem_pulse !== p0)
      $display("FAIL backpressure_hold got rd=%h valid=%b exp rd=%h valid=1", resp_rdata,
               resp_valid, exp_rd);
    else n_pass++;
    resp_ready = 1'b1;
    step();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL backpressure_release got valid=%b ready=%b exp 0/1", resp_valid,
               req_ready);
    else n_pass++;
    run_req(1'b0, 64'h8000_0010, '0, SZ_W, 1'b1, rd, err, lat, pulses);
    n_checks++;
    if (rd !== ref_load(64'h8000_0010, SZ_W, 1'b1) || lat !== 3)
      $display("FAIL backpressure_next got rd=%h lat=%0d exp rd=%h lat=3", rd, lat,
               ref_load(64'h8000_0010, SZ_W, 1'b1));
    else n_pass++;
  endtask

  task automatic test_reset_during_issue();
    logic bad;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020; req_size = SZ_D;
    req_unsigned = 1'b0;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (mem_valid !== 1'b1) $display("FAIL abort_issue_c1 got mem_valid=%b exp=1", mem_valid);
    else n_pass++;
    reset = 1'b1;
    step();
    n_checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL abort_outputs got mem_valid=%b resp_valid=%b ready=%b exp 0/0/0",
               mem_valid, resp_valid, req_ready);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL abort_ready got=%b exp=1", req_ready);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid !== 1'b0 || mem_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL abort_no_resp got spurious activity=%b exp=0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, a;
    logic err;
    int lat, pulses, q0;
    q0 = mem_cycles.size();
    for (int i = 0; i < 6; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 15) * 8);
      run_req(1'b0, a, '0, SZ_D, 1'b0, rd, err, lat, pulses);
      n_checks++;
      if (rd !== ref_load(a, SZ_D, 1'b0) || err !== 1'b0)
        $display("FAIL b2b_data[%0d] addr=%h got=%h exp=%h", i, a, rd, ref_load(a, SZ_D, 1'b0));
      else n_pass++;
    end
    n_checks++;
    if (mem_cycles.size() - q0 !== 6)
      $display("FAIL b2b_pulse_count got=%0d exp=6", mem_cycles.size() - q0);
    else n_pass++;
    for (int i = q0 + 1; i < mem_cycles.size(); i++) begin
      n_checks++;
      if (mem_cycles[i] - mem_cycles[i-1] !== 4)
        $display("FAIL b2b_interval[%0d] got=%0d exp=4", i - q0,
                 mem_cycles[i] - mem_cycles[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, a, wd, exp_rd;
    logic [1:0]  sz;
    logic        wen, uns, err, mis;
    int lat, pulses;
    for (int i = 0; i < 60; i++) begin
      a   = 64'h8000_0000 + 64'($urandom_range(0, 127));
      sz  = 2'($urandom_range(0, 3));
      wen = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      mis = ref_misaligned(a, sz);
      exp_rd = (mis || wen) ? 64'd0 : ref_load(a, sz, uns);
      run_req(wen, a, wd, sz, uns, rd, err, lat, pulses);
      if (!mis && wen) ref_store(a, wd, sz);
      n_checks++;
      if (rd !== exp_rd || err !== mis)
        $display("FAIL rand_resp[%0d] a=%h sz=%0d wen=%b got rd=%h err=%b exp rd=%h err=%b", i,
                 a, sz, wen, rd, err, exp_rd, mis);
      else n_pass++;
      n_checks++;
      if (lat !== (mis ? 1 : 3) || pulses !== (mis ? 0 : 1))
        $display("FAIL rand_timing[%0d] got lat=%0d pulses=%0d exp lat=%0d pulses=%0d", i, lat,
                 pulses, mis ? 1 : 3, mis ? 0 : 1);
      else n_pass++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_backpressure();
    test_reset_during_issue();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
